// File: rtl/keypad_word_loader.sv
// Builds a 16-bit word from four synchronized hex key presses and writes it to the
// downstream register with a one-cycle WE. Optional inactivity timeout: KEYPAD_LOADER_TIMEOUT_EN.
module keypad_word_loader #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_pressed,
    input  logic [3:0]  key_code,
    input  logic        clear,
    output logic [15:0] D,
    output logic        WE,
    output logic [2:0]  digit_cnt,
    output logic        entry_active
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMMIT
    } state_e;

    // Illegal parameterisations stop elaboration.
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("keypad_word_loader: SYNC_STAGES and TIMEOUT_CYCLES must both be >= 2");
    end

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                ks_d_q;
    logic                ks;
    logic                acc;
    logic                acc_ok;

`ifdef KEYPAD_LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

    assign ks     = sync_q[SYNC_STAGES-1];
    assign acc    = ks & ~ks_d_q;
    assign acc_ok = acc & ~clear;

    // Key strobe synchronizer and rising-edge history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            ks_d_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_pressed};
            ks_d_q <= ks;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
        end
    end

`ifdef KEYPAD_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
`ifdef KEYPAD_LOADER_TIMEOUT_EN
        tmo_d   = '0;
`endif

        if (acc_ok) begin
            d_d = {d_q[DATA_W-5:0], key_code};
        end

        unique case (state_q)
            ST_IDLE: begin
                if (acc_ok) begin
                    state_d = ST_COLLECT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_COLLECT: begin
                if (acc_ok) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(3)) begin
                        state_d = ST_COMMIT;
                        we_d    = 1'b1;
                    end
`ifdef KEYPAD_LOADER_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 2)) begin
                    // Counter would reach TIMEOUT_CYCLES-1: abandon the partial word.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            ST_COMMIT: begin
                if (acc_ok) begin
                    state_d = ST_COLLECT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort wins over any simultaneous accept; D stays as it was.
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            we_d    = 1'b0;
`ifdef KEYPAD_LOADER_TIMEOUT_EN
            tmo_d   = '0;
`endif
        end
    end

    assign D            = d_q;
    assign WE           = we_q;
    assign digit_cnt    = cnt_q;
    assign entry_active = (cnt_q != '0);

endmodule

// File: tb/tb_keypad_word_loader.sv
// Directed bench for keypad_word_loader with a model of the downstream 16-bit register.
module tb_keypad_word_loader;

    logic        clk;
    logic        rst;
    logic        key_pressed;
    logic [3:0]  key_code;
    logic        clear;
    logic [15:0] D;
    logic        WE;
    logic [2:0]  digit_cnt;
    logic        entry_active;

    logic [15:0] reg_q;
    int          we_pulses;
    int          we_double;
    logic        we_prev;
    int          n_checks;
    int          n_fail;

    keypad_word_loader #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_pressed (key_pressed),
        .key_code    (key_code),
        .clear       (clear),
        .D           (D),
        .WE          (WE),
        .digit_cnt   (digit_cnt),
        .entry_active(entry_active)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Downstream register and WE pulse monitor.
    always @(posedge clk) begin
        if (WE === 1'b1) begin
            reg_q <= D;
            we_pulses++;
            if (we_prev) we_double++;
        end
        we_prev = (WE === 1'b1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        key_code = code;
        repeat (3) @(negedge clk);
        key_pressed = 1'b1;
        repeat (20) @(negedge clk);
        key_pressed = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        we_pulses   = 0;
        we_double   = 0;
        we_prev     = 1'b0;
        reg_q       = 16'h0000;
        rst         = 1'b1;
        key_pressed = 1'b0;
        key_code    = 4'h0;
        clear       = 1'b0;

        #10;
        check("rst_D", D, 16'h0000);
        check("rst_WE", 16'(WE), 16'h0);
        check("rst_cnt", 16'(digit_cnt), 16'h0);
        check("rst_active", 16'(entry_active), 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1, 2, A, F
        press(4'h1);
        check("p1_cnt", 16'(digit_cnt), 16'h1);
        check("p1_D", D, 16'h0001);
        check("p1_active", 16'(entry_active), 16'h1);
        press(4'h2);
        check("p2_cnt", 16'(digit_cnt), 16'h2);
        press(4'hA);
        check("p3_cnt", 16'(digit_cnt), 16'h3);
        check("p3_D", D, 16'h012A);
        key_code = 4'hF;
        repeat (3) @(negedge clk);
        key_pressed = 1'b1;
        @(negedge clk);
        check("p4_we_n1", 16'(WE), 16'h0);
        @(negedge clk);
        check("p4_we_n2", 16'(WE), 16'h0);
        @(negedge clk);
        check("p4_we_hi", 16'(WE), 16'h1);
        check("p4_D", D, 16'h12AF);
        check("p4_cnt", 16'(digit_cnt), 16'h4);
        @(negedge clk);
        check("p4_we_lo", 16'(WE), 16'h0);
        check("p4_cnt_after", 16'(digit_cnt), 16'h0);
        check("p4_reg", reg_q, 16'h12AF);
        repeat (16) @(negedge clk);
        key_pressed = 1'b0;
        repeat (20) @(negedge clk);

        // Long hold: single nibble
        key_code = 4'h5;
        repeat (3) @(negedge clk);
        key_pressed = 1'b1;
        repeat (200) @(negedge clk);
        key_pressed = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_cnt", 16'(digit_cnt), 16'h1);
        check("hold_D", D, 16'h2AF5);
        check("hold_we", 16'(we_pulses), 16'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_cnt", 16'(digit_cnt), 16'h0);
        check("clr_D", D, 16'h2AF5);
        check("clr_active", 16'(entry_active), 16'h0);

        // 3, 7, then clear coincident with third accept
        press(4'h3);
        press(4'h7);
        check("c37_D", D, 16'hF537);
        check("c37_cnt", 16'(digit_cnt), 16'h2);
        key_code = 4'h9;
        repeat (3) @(negedge clk);
        key_pressed = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("cacc_cnt", 16'(digit_cnt), 16'h0);
        check("cacc_D", D, 16'hF537);
        check("cacc_we", 16'(WE), 16'h0);
        repeat (17) @(negedge clk);
        key_pressed = 1'b0;
        repeat (20) @(negedge clk);
        check("cacc_cnt_late", 16'(digit_cnt), 16'h0);
        press(4'hB);
        press(4'hE);
        press(4'hE);
        press(4'hF);
        check("beef_reg", reg_q, 16'hBEEF);
        check("beef_D", D, 16'hBEEF);
        check("beef_cnt", 16'(digit_cnt), 16'h0);
        check("beef_we", 16'(we_pulses), 16'd2);

        // Inactivity after a single nibble
        key_code = 4'h1;
        repeat (3) @(negedge clk);
        key_pressed = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_cnt0", 16'(digit_cnt), 16'h1);
`ifdef KEYPAD_LOADER_TIMEOUT_EN
        repeat (18) @(negedge clk);
        check("tmo_cnt_18", 16'(digit_cnt), 16'h1);
        @(negedge clk);
        check("tmo_cnt_19", 16'(digit_cnt), 16'h0);
        check("tmo_D", D, 16'hEEF1);
        key_pressed = 1'b0;
        repeat (5) @(negedge clk);

        key_code = 4'h2;
        repeat (3) @(negedge clk);
        key_pressed = 1'b1;
        repeat (3) @(negedge clk);
        key_pressed = 1'b0;
        key_code    = 4'h3;
        repeat (15) @(negedge clk);
        key_pressed = 1'b1;
        repeat (3) @(negedge clk);
        check("tmo_keep_cnt", 16'(digit_cnt), 16'h2);
        check("tmo_keep_D", D, 16'hF123);
        repeat (18) @(negedge clk);
        check("tmo2_cnt_18", 16'(digit_cnt), 16'h2);
        @(negedge clk);
        check("tmo2_cnt_19", 16'(digit_cnt), 16'h0);
        key_pressed = 1'b0;
        repeat (5) @(negedge clk);
`else
        key_pressed = 1'b0;
        repeat (1000) @(negedge clk);
        check("notmo_cnt", 16'(digit_cnt), 16'h1);
        check("notmo_active", 16'(entry_active), 16'h1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
`endif
        check("idle_we", 16'(we_pulses), 16'd2);

        // Asynchronous reset mid-entry
        press(4'h4);
        press(4'h6);
        check("pre_rst_cnt", 16'(digit_cnt), 16'h2);
        @(negedge clk);
        #20;
        rst = 1'b1;
        #1;
        check("arst_D", D, 16'h0000);
        check("arst_WE", 16'(WE), 16'h0);
        check("arst_cnt", 16'(digit_cnt), 16'h0);
        check("arst_active", 16'(entry_active), 16'h0);
        @(negedge clk);
        #20;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_cnt", 16'(digit_cnt), 16'h0);
        check("post_rst_we", 16'(we_pulses), 16'd2);
        check("we_single", 16'(we_double), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
